// File: rtl/full_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
package full_adder_pkg;

    localparam int unsigned FA_DEFAULT_N = 4;

    // Reset values: the sum register clears to all zeros, carry-out to 0.
    localparam logic FA_SUM_RST_BIT = 1'b0;
    localparam logic FA_C_OUT_RST   = 1'b0;

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full-adder cell used as one link of the ripple chain.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);

endmodule

// File: rtl/full_adder.sv
// N-bit ripple-carry adder with a registered {c_out, sum} and valid flag.
// Optional signed-overflow output enabled by defining FULL_ADDER_OVF_EN.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned N = FA_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         out_valid
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    // carry[i] is the carry into bit i; carry[N] is the final carry-out.
    logic [N:0]   carry;
    logic [N-1:0] sum_c;

    assign carry[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_chain
        full_adder_bit u_bit (
            .x  (a[i]),
            .y  (b[i]),
            .ci (carry[i]),
            .s  (sum_c[i]),
            .co (carry[i+1])
        );
    end

    // Result register: loads on in_valid, otherwise holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum       <= {N{FA_SUM_RST_BIT}};
            c_out     <= FA_C_OUT_RST;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum   <= sum_c;
                c_out <= carry[N];
            end
        end
    end

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow: carry into the MSB disagrees with carry out of it.
    logic ovf_c;

    assign ovf_c = carry[N-1] ^ carry[N];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= ovf_c;
        end
    end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed and exhaustive self-checking bench for full_adder at N=4.
module tb_full_adder;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic [N-1:0] sum;
    logic         c_out;
    logic         out_valid;
`ifdef FULL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state tracked by the bench
    logic [N-1:0] exp_sum   = '0;
    logic         exp_c_out = 1'b0;
    logic         exp_ovf   = 1'b0;

    full_adder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sum       (sum),
        .c_out     (c_out),
        .out_valid (out_valid)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, update the model and compare.
    task automatic step(input string tag, input logic rst, input logic vld,
                        input logic [N-1:0] ta, input logic [N-1:0] tb_, input logic tc);
        logic [N:0] full;
        rst_n    = rst;
        in_valid = vld;
        a        = ta;
        b        = tb_;
        c_in     = tc;
        @(posedge clk);
        #1;
        full = (N+1)'(ta) + (N+1)'(tb_) + (N+1)'(tc);
        if (!rst) begin
            exp_sum   = '0;
            exp_c_out = 1'b0;
            exp_ovf   = 1'b0;
        end else if (vld) begin
            exp_sum   = full[N-1:0];
            exp_c_out = full[N];
            exp_ovf   = (ta[N-1] == tb_[N-1]) && (full[N-1] != ta[N-1]);
        end
        check({tag, ".sum"},       8'(sum),       8'(exp_sum));
        check({tag, ".c_out"},     8'(c_out),     8'(exp_c_out));
        check({tag, ".out_valid"}, 8'(out_valid), 8'(rst & vld));
`ifdef FULL_ADDER_OVF_EN
        check({tag, ".ovf"},       8'(ovf),       8'(exp_ovf));
`endif
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        c_in     = 1'b0;
        #2;

        // Reset dominates in_valid
        step("rst0", 1'b0, 1'b1, 4'h5, 4'h3, 1'b0);
        step("rst1", 1'b0, 1'b1, 4'h5, 4'h3, 1'b0);
        check("rst.sum_const",  8'(sum),   8'h00);

        step("add_3_4_1", 1'b1, 1'b1, 4'h3, 4'h4, 1'b1);
        check("add_3_4_1.sum_const", 8'(sum), 8'h08);
`ifdef FULL_ADDER_OVF_EN
        check("add_3_4_1.ovf_const", 8'(ovf), 8'h01);
`endif
        step("wrap_f_1", 1'b1, 1'b1, 4'hF, 4'h1, 1'b0);
        check("wrap_f_1.cout_const", 8'(c_out), 8'h01);
        step("max_f_f_1", 1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
        check("max_f_f_1.sum_const", 8'(sum), 8'h0F);
        step("hold", 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        check("hold.sum_const", 8'(sum), 8'h0F);
        check("hold.cout_const", 8'(c_out), 8'h01);

        // Exhaustive, back-to-back, with a reset in the middle
        for (int i = 0; i < 512; i++) begin
            if (i == 300) begin
                step("mid_rst", 1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
                check("mid_rst.sum_const", 8'(sum), 8'h00);
            end
            step($sformatf("exh%0d", i), 1'b1, 1'b1, N'(i), N'(i >> 4), 1'(i >> 8));
        end

        step("final_idle", 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
